// File: rtl/rob_wb_arbiter_if.sv
// Writeback-arbiter bus: per-requester completion handshakes, flush control
// and the registered ROB writeback port.
interface rob_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ROB_W   = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*ROB_W-1:0] req_rob_idx;
   logic [NUM_REQ-1:0]       req_epoch;
   logic                     flush_valid;
   logic                     flush_epoch;
   logic                     wb_valid;
   logic [ROB_W-1:0]         wb_rob_idx;
   logic                     wb_epoch;
   logic                     cur_epoch;
   logic                     stale_drop;

   modport master (
      output req_valid, req_rob_idx, req_epoch, flush_valid, flush_epoch,
      input  req_ready, wb_valid, wb_rob_idx, wb_epoch, cur_epoch, stale_drop
   );

   modport slave (
      input  req_valid, req_rob_idx, req_epoch, flush_valid, flush_epoch,
      output req_ready, wb_valid, wb_rob_idx, wb_epoch, cur_epoch, stale_drop
   );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter merging per-unit completion FIFOs onto the ROB's single
// writeback port, with epoch filtering and flush of all buffered entries.
module rob_wb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ROB_SIZE   = 16,
   parameter int ROB_W      = $clog2(ROB_SIZE),
   parameter int FIFO_DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   rob_wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ROB_W-1:0] mem_idx [NUM_REQ][FIFO_DEPTH];
   logic             mem_ep  [NUM_REQ][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr  [NUM_REQ];
   logic [PTR_W-1:0] rd_ptr  [NUM_REQ];
   logic [CNT_W-1:0] count   [NUM_REQ];

   logic [NUM_REQ-1:0] ready, push, pop, stale;
   logic [RR_W-1:0]    rr_ptr, grant_idx;
   logic               grant_vld;
   logic [ROB_W-1:0]   head_idx;
   logic               head_ep;
   int                 j;

   logic             wb_valid, wb_epoch, cur_epoch, stale_drop;
   logic [ROB_W-1:0] wb_rob_idx;

   // Handshake decode; a flush swallows every same-cycle handshake silently.
   always_comb begin
      ready = '0;
      push  = '0;
      stale = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
         if (bus.req_valid[i] && ready[i] && !bus.flush_valid) begin
            if (bus.req_epoch[i] == cur_epoch) push[i]  = 1'b1;
            else                               stale[i] = 1'b1;
         end
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      head_idx  = '0;
      head_ep   = 1'b0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!grant_vld && count[j] != '0) begin
            grant_vld = 1'b1;
            grant_idx = RR_W'(j);
            head_idx  = mem_idx[j][rd_ptr[j]];
            head_ep   = mem_ep[j][rd_ptr[j]];
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_REQ; i++)
         pop[i] = grant_vld && !bus.flush_valid && (grant_idx == RR_W'(i));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push[i]) begin
            mem_idx[i][wr_ptr[i]] <= bus.req_rob_idx[i*ROB_W +: ROB_W];
            mem_ep[i][wr_ptr[i]]  <= bus.req_epoch[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         wb_valid   <= 1'b0;
         wb_rob_idx <= '0;
         wb_epoch   <= 1'b0;
         cur_epoch  <= 1'b0;
         stale_drop <= 1'b0;
         rr_ptr     <= '0;
      end else if (bus.flush_valid) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         wb_valid   <= 1'b0;
         cur_epoch  <= bus.flush_epoch;
         stale_drop <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
         wb_valid   <= grant_vld;
         stale_drop <= |stale;
         if (grant_vld) begin
            wb_rob_idx <= head_idx;
            wb_epoch   <= head_ep;
            rr_ptr     <= (grant_idx == RR_W'(NUM_REQ-1)) ? '0 : grant_idx + RR_W'(1);
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.wb_valid   = wb_valid;
   assign bus.wb_rob_idx = wb_rob_idx;
   assign bus.wb_epoch   = wb_epoch;
   assign bus.cur_epoch  = cur_epoch;
   assign bus.stale_drop = stale_drop;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: a vector table for ordering, flush and
// epoch behaviour, plus sequences for backpressure fairness and reset.
module tb_rob_wb_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rob_wb_arbiter_if #(.NUM_REQ(3), .ROB_W(4)) bus ();
   rob_wb_arbiter #(.NUM_REQ(3), .ROB_SIZE(16), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [2:0] v;
      logic [3:0] i0, i1, i2;
      logic [2:0] ep;
      logic       fl, fe;
      logic       wv;
      logic [3:0] wi;
      logic       we;
      logic [2:0] rdy;
      logic       ce, sd;
   } vec_t;

   vec_t tbl[18];
   int total = 0;
   int bad   = 0;

   function automatic vec_t mk(logic [2:0] v, logic [3:0] i0, logic [3:0] i1, logic [3:0] i2,
                               logic [2:0] ep, logic fl, logic fe, logic wv, logic [3:0] wi,
                               logic we, logic [2:0] rdy, logic ce, logic sd);
      vec_t r;
      r.v = v; r.i0 = i0; r.i1 = i1; r.i2 = i2; r.ep = ep; r.fl = fl; r.fe = fe;
      r.wv = wv; r.wi = wi; r.we = we; r.rdy = rdy; r.ce = ce; r.sd = sd;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {21'd0, bus.wb_valid, bus.wb_rob_idx, bus.wb_epoch, bus.req_ready,
              bus.cur_epoch, bus.stale_drop};
   endfunction

   function automatic logic [31:0] want(logic wv, logic [3:0] wi, logic we, logic [2:0] rdy,
                                        logic ce, logic sd);
      return {21'd0, wv, wi, we, rdy, ce, sd};
   endfunction

   task automatic drive(logic [2:0] v, logic [3:0] i0, logic [3:0] i1, logic [3:0] i2,
                        logic [2:0] ep, logic fl, logic fe);
      bus.req_valid   = v;
      bus.req_rob_idx = {i2, i1, i0};
      bus.req_epoch   = ep;
      bus.flush_valid = fl;
      bus.flush_epoch = fe;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             v     i0 i1 i2 ep    fl fe  wv wi we rdy   ce sd
      tbl[0]  = mk(3'b111, 1, 2, 3, 3'b000, 0, 0, 0, 0, 0, 3'b111, 0, 0);
      tbl[1]  = mk(3'b001, 6, 0, 0, 3'b000, 0, 0, 1, 1, 0, 3'b111, 0, 0);
      tbl[2]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 2, 0, 3'b111, 0, 0);
      tbl[3]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 3, 0, 3'b111, 0, 0);
      tbl[4]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 6, 0, 3'b111, 0, 0);
      tbl[5]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 6, 0, 3'b111, 0, 0);
      tbl[6]  = mk(3'b001, 5, 0, 0, 3'b000, 0, 0, 0, 6, 0, 3'b111, 0, 0);
      tbl[7]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 5, 0, 3'b111, 0, 0);
      tbl[8]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 3'b111, 0, 0);
      tbl[9]  = mk(3'b100, 0, 0, 7, 3'b000, 0, 0, 0, 5, 0, 3'b111, 0, 0);
      tbl[10] = mk(3'b100, 0, 0, 8, 3'b000, 1, 1, 0, 5, 0, 3'b111, 1, 0);
      tbl[11] = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 3'b111, 1, 0);
      tbl[12] = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 3'b111, 1, 0);
      tbl[13] = mk(3'b001, 4, 0, 0, 3'b000, 0, 0, 0, 5, 0, 3'b111, 1, 1);
      tbl[14] = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 5, 0, 3'b111, 1, 0);
      tbl[15] = mk(3'b001, 4, 0, 0, 3'b001, 0, 0, 0, 5, 0, 3'b111, 1, 0);
      tbl[16] = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 4, 1, 3'b111, 1, 0);
      tbl[17] = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 4, 1, 3'b111, 1, 0);

      rst = 1'b1;
      drive(3'b000, 0, 0, 0, 3'b000, 0, 0);
      tick();
      tick();
      chk("reset_state", outs(), want(0, 0, 0, 3'b111, 0, 0));
      rst = 1'b0;

      for (int r = 0; r < 18; r++) begin
         drive(tbl[r].v, tbl[r].i0, tbl[r].i1, tbl[r].i2, tbl[r].ep, tbl[r].fl, tbl[r].fe);
         tick();
         chk($sformatf("row%0d", r), outs(),
             want(tbl[r].wv, tbl[r].wi, tbl[r].we, tbl[r].rdy, tbl[r].ce, tbl[r].sd));
      end

      // All three requesters saturated from rr_ptr=1: grants rotate 1,2,0 and
      // each FIFO in turn sits full with its ready low.
      begin
         logic [3:0] exp_idx [7];
         logic [2:0] exp_rdy [7];
         exp_idx = '{4'd4, 4'd11, 4'd12, 4'd10, 4'd11, 4'd12, 4'd10};
         exp_rdy = '{3'b111, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
         drive(3'b111, 10, 11, 12, 3'b111, 0, 0);
         for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("fair%0d", c), outs(),
                want(c != 0, exp_idx[c], 1'b1, exp_rdy[c], 1'b1, 1'b0));
         end
      end

      // Reset with entries buffered and a writeback in flight.
      drive(3'b000, 0, 0, 0, 3'b000, 0, 0);
      rst = 1'b1;
      tick();
      chk("rst_mid", outs(), want(0, 0, 0, 3'b111, 0, 0));
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("post_rst%0d", c), outs(), want(0, 0, 0, 3'b111, 0, 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rob_wb_arbiter.md
# rob_wb_arbiter

Arbitrates completion (writeback) notifications from several execution units onto the ROB's single writeback port (`wb_valid`/`wb_rob_idx`/`wb_epoch`).
- Each requester has a small private FIFO; FIFO heads are granted round-robin, one per cycle.
- Notifications tagged with a stale epoch are discarded.
- On a flush, all buffered notifications are dropped so none reaches the ROB after the flush.

## Interface
Parameters:
- `NUM_REQ`, 3 — number of requesters (ALU, branch, LSU).
- `ROB_SIZE`, 16 — ROB entries.
- `ROB_W`, `$clog2(ROB_SIZE)` — ROB index width.
- `FIFO_DEPTH`, 2 — entries per requester FIFO; power of two, ≥2.

Ports:
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in `NUM_REQ` — per-requester completion valid.
- `req_ready` out `NUM_REQ` — per-requester FIFO not full.
- `req_rob_idx` in `NUM_REQ*ROB_W` — requester i's ROB index in bits [i*ROB_W +: ROB_W].
- `req_epoch` in `NUM_REQ` — epoch tag per requester.
- `flush_valid` in 1 — global flush pulse.
- `flush_epoch` in 1 — epoch in force after the flush.
- `wb_valid` out 1 — registered; drives the ROB writeback valid (always accepted, no ready).
- `wb_rob_idx` out `ROB_W` — registered; ROB index being marked done.
- `wb_epoch` out 1 — registered; epoch of the granted entry.
- `cur_epoch` out 1 — current accepted epoch.
- `stale_drop` out 1 — registered one-cycle pulse: at least one request was discarded for stale epoch.

## Operation
- Reset (`rst`=1 at an edge):
  - all FIFOs empty; `req_ready` = all ones.
  - `wb_valid`=0, `wb_rob_idx`=0, `wb_epoch`=0.
  - `cur_epoch`=0, `stale_drop`=0, `rr_ptr`=0.
  - `rst` overrides flush and every handshake in the same cycle.
- Enqueue:
  - Requester i handshakes when `req_valid[i] && req_ready[i]`.
  - If `req_epoch[i]==cur_epoch`, the entry {`rob_idx`, `epoch`} is pushed into FIFO i.
  - Otherwise the handshake completes, nothing is stored, and `stale_drop`=1 in the next cycle.
  - Multiple requesters may enqueue in the same cycle.
- `req_ready[i]` = FIFO i count < `FIFO_DEPTH`, from the registered count only. A same-cycle pop does not free space for a same-cycle push.
- Arbitration (combinational over FIFO heads):
  - Scan non-empty FIFOs starting at `rr_ptr`, ascending mod `NUM_REQ`; the first one found is granted.
  - At the edge: pop the granted head, load `wb_*` from it, set `wb_valid`=1, `rr_ptr` ← (grant+1) mod `NUM_REQ`.
  - No FIFO non-empty: `wb_valid`←0, `rr_ptr` unchanged, `wb_rob_idx`/`wb_epoch` hold.
- Flush (`flush_valid`=1 at an edge):
  - all FIFOs emptied.
  - `wb_valid`←0 (no grant that cycle).
  - `cur_epoch`←`flush_epoch`; `rr_ptr` unchanged.
  - Requests handshaking in the flush cycle are accepted and discarded; they do not set `stale_drop`.
  - A `wb_valid` already high during the flush cycle stays visible that cycle; the ROB filters it by epoch.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(FIFO_DEPTH)+1` bits.
- Simultaneous push and pop on one FIFO: count unchanged, both take effect.

## Timing
- Minimum latency:
  - request handshake at edge T;
  - granted no earlier than the cycle after T, popped and registered at edge T+1;
  - `wb_valid` high in the cycle after edge T+1.
- Throughput: one writeback per cycle while any FIFO is non-empty.
- Back-to-back requests from one requester at full rate with no competition: sustained, `req_ready` never drops.
- Fairness: with all FIFOs continuously non-empty, each requester is granted exactly once every `NUM_REQ` cycles.
- `stale_drop` follows its cause by exactly one cycle. `cur_epoch` changes in the cycle after the flush edge.
- `wb_valid` never asserts in the cycle immediately after a flush edge.

## Test plan
- Reset, then requester 0 sends `rob_idx`=5, epoch 0 at edge T → `wb_valid`=1, `wb_rob_idx`=5, `wb_epoch`=0 in the cycle after T+1, then `wb_valid`=0.
- All three requesters send one entry in the same cycle (idx 1, 2, 3) with `rr_ptr`=0 → writebacks 1, 2, 3 on three consecutive cycles; a follow-up single request on requester 0 is granted next.
- Requester 1 holds `req_valid` with `wb` idle but its FIFO stalled behind continuous grants to 0 and 2 (all busy) → FIFO 1 fills to 2, `req_ready[1]`=0, and still receives every third grant.
- Enqueue idx 7 and 8 (requester 2), flush with `flush_epoch`=1 before they drain → no `wb_valid` for 7/8 afterwards; `cur_epoch`=1 from the cycle after the flush.
- After the flush to epoch 1, requester 0 sends idx 4 epoch 0 → `req_ready` honoured, `stale_drop` pulses 1 cycle later, no writeback. Then idx 4 epoch 1 → writeback idx 4, `wb_epoch`=1.
- `rst` asserted while 2 entries are buffered and `wb_valid`=1 → next cycle all outputs at reset values, `req_ready`=3'b111, and no buffered entry is ever emitted.
